// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer configuration: default sizes, entry type codes and
// the branch-outcome helper used at commit.
package reorder_buffer_pkg;

    localparam int ROB_SIZE_BIT_DEF = 4;
    localparam int ROB_TYPE_BIT_DEF = 2;

    typedef enum logic [1:0] {
        ROB_REG  = 2'd0,
        ROB_REGI = 2'd1,
        ROB_BR   = 2'd2,
        ROB_ST   = 2'd3
    } rob_type_e;

    // A branch was mispredicted when the predicted-taken bit disagrees with
    // the actual-taken bit delivered on the CDB.
    function automatic logic br_mispredict(input logic predicted, input logic actual);
        return predicted != actual;
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order issue, CDB completion, one in-order
// commit per cycle, branch-mispredict flush and operand queries with CDB
// bypass. Optional performance counters are built when ROB_PERF_CNT_EN is
// defined; otherwise the perf ports are tied to zero.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_SIZE_BIT = ROB_SIZE_BIT_DEF,
    parameter int ROB_TYPE_BIT = ROB_TYPE_BIT_DEF
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    rob_input,
    input  logic                    rob_fi,
    input  logic [31:0]             rob_value,
    input  logic [31:0]             rob_addr,
    input  logic [ROB_TYPE_BIT-1:0] rob_type,
    input  logic [4:0]              rob_reg_id,
    output logic                    rob_full,
    output logic [ROB_SIZE_BIT-1:0] rob_vacant_id,
    input  logic [ROB_SIZE_BIT-1:0] rob_qry1_id,
    input  logic [ROB_SIZE_BIT-1:0] rob_qry2_id,
    output logic                    rob_qry1_fi,
    output logic                    rob_qry2_fi,
    output logic [31:0]             rob_qry1_value,
    output logic [31:0]             rob_qry2_value,
    input  logic                    cdb_valid,
    input  logic [ROB_SIZE_BIT-1:0] cdb_rob_id,
    input  logic [31:0]             cdb_value,
    output logic                    rob_clear,
    output logic [31:0]             rob_clear_pc,
    output logic                    rf_commit_en,
    output logic [4:0]              rf_commit_reg,
    output logic [31:0]             rf_commit_value,
    output logic [ROB_SIZE_BIT-1:0] rf_commit_rob_id,
    output logic                    lsb_commit_en,
    output logic [ROB_SIZE_BIT-1:0] lsb_commit_rob_id,
    output logic [31:0]             perf_commit_cnt,
    output logic [31:0]             perf_mispredict_cnt
);

    localparam int ROB_SIZE = 1 << ROB_SIZE_BIT;
    // Full is raised one slot early: the decoder has one registered issue in flight.
    localparam logic [ROB_SIZE_BIT:0] FULL_MARK = (ROB_SIZE_BIT + 1)'(ROB_SIZE - 1);
    localparam logic [ROB_SIZE_BIT:0] CAPACITY  = (ROB_SIZE_BIT + 1)'(ROB_SIZE);

    logic [ROB_SIZE_BIT-1:0] head;
    logic [ROB_SIZE_BIT-1:0] tail;
    logic [ROB_SIZE_BIT:0]   count;
    logic [ROB_SIZE-1:0]     busy;
    logic [ROB_SIZE-1:0]     ready;
    logic [ROB_TYPE_BIT-1:0] entry_type  [ROB_SIZE];
    logic [4:0]              entry_reg   [ROB_SIZE];
    logic [31:0]             entry_value [ROB_SIZE];
    logic [31:0]             entry_addr  [ROB_SIZE];

    logic do_issue;
    logic do_wb;
    logic do_commit;
    logic do_flush;
    logic head_is_reg;
    logic head_is_st;
    logic qry1_hit;
    logic qry2_hit;

    // Decode this cycle's issue, writeback, commit and flush decisions.
    always_comb begin
        do_issue    = rob_input && !rob_clear && (count != CAPACITY);
        do_wb       = cdb_valid && !rob_clear && busy[cdb_rob_id];
        do_commit   = busy[head] && ready[head];
        head_is_reg = (entry_type[head] == ROB_TYPE_BIT'(ROB_REG)) ||
                      (entry_type[head] == ROB_TYPE_BIT'(ROB_REGI));
        head_is_st  = (entry_type[head] == ROB_TYPE_BIT'(ROB_ST));
        do_flush    = do_commit && (entry_type[head] == ROB_TYPE_BIT'(ROB_BR)) &&
                      br_mispredict(entry_reg[head][0], entry_value[head][0]);
    end

    // Dependency queries, with the CDB result bypassing the stored entry.
    always_comb begin
        qry1_hit       = cdb_valid && (cdb_rob_id == rob_qry1_id);
        qry2_hit       = cdb_valid && (cdb_rob_id == rob_qry2_id);
        rob_qry1_fi    = (busy[rob_qry1_id] && ready[rob_qry1_id]) || qry1_hit;
        rob_qry2_fi    = (busy[rob_qry2_id] && ready[rob_qry2_id]) || qry2_hit;
        rob_qry1_value = qry1_hit ? cdb_value : entry_value[rob_qry1_id];
        rob_qry2_value = qry2_hit ? cdb_value : entry_value[rob_qry2_id];
    end

    assign rob_full      = (count >= FULL_MARK);
    assign rob_vacant_id = tail;

    // Control state: pointers, occupancy, busy/ready flags and commit/flush outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            busy              <= '0;
            ready             <= '0;
            rob_clear         <= 1'b0;
            rob_clear_pc      <= '0;
            rf_commit_en      <= 1'b0;
            rf_commit_reg     <= '0;
            rf_commit_value   <= '0;
            rf_commit_rob_id  <= '0;
            lsb_commit_en     <= 1'b0;
            lsb_commit_rob_id <= '0;
        end else if (!rdy_in) begin
            rob_clear     <= 1'b0;
            rf_commit_en  <= 1'b0;
            lsb_commit_en <= 1'b0;
        end else begin
            rob_clear     <= 1'b0;
            rf_commit_en  <= 1'b0;
            lsb_commit_en <= 1'b0;
            if (do_commit && head_is_reg) begin
                // x0 retires silently so the register file never sees a write to it.
                rf_commit_en     <= (entry_reg[head] != 5'd0);
                rf_commit_reg    <= entry_reg[head];
                rf_commit_value  <= entry_value[head];
                rf_commit_rob_id <= head;
            end
            if (do_commit && head_is_st) begin
                lsb_commit_en     <= 1'b1;
                lsb_commit_rob_id <= head;
            end
            if (do_flush) begin
                busy         <= '0;
                head         <= '0;
                tail         <= '0;
                count        <= '0;
                rob_clear    <= 1'b1;
                rob_clear_pc <= entry_addr[head];
            end else begin
                if (do_wb) begin
                    ready[cdb_rob_id] <= 1'b1;
                end
                if (do_issue) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= rob_fi;
                    tail        <= tail + 1'b1;
                end
                if (do_commit) begin
                    busy[head] <= 1'b0;
                    head       <= head + 1'b1;
                end
                case ({do_issue, do_commit})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Entry payload storage: written on issue and on CDB completion.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !do_flush) begin
            if (do_wb) begin
                entry_value[cdb_rob_id] <= cdb_value;
            end
            if (do_issue) begin
                entry_type[tail]  <= rob_type;
                entry_reg[tail]   <= rob_reg_id;
                entry_value[tail] <= rob_value;
                entry_addr[tail]  <= rob_addr;
            end
        end
    end

    // Issuing into a completely occupied buffer is a decoder protocol error.
    always_ff @(posedge clk_in) begin
        if (rst_in && rdy_in && rob_input && !rob_clear) begin
            assert (count != CAPACITY);
        end
    end

`ifdef ROB_PERF_CNT_EN
    // Retired-instruction and mispredict counters, held while paused.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            perf_commit_cnt     <= '0;
            perf_mispredict_cnt <= '0;
        end else if (rdy_in) begin
            if (do_commit) begin
                perf_commit_cnt <= perf_commit_cnt + 32'd1;
            end
            if (do_flush) begin
                perf_mispredict_cnt <= perf_mispredict_cnt + 32'd1;
            end
        end
    end
`else
    assign perf_commit_cnt     = '0;
    assign perf_mispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: query vector table, directed
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_input;
    logic        rob_fi;
    logic [31:0] rob_value;
    logic [31:0] rob_addr;
    logic [1:0]  rob_type;
    logic [4:0]  rob_reg_id;
    logic        rob_full;
    logic [3:0]  rob_vacant_id;
    logic [3:0]  rob_qry1_id;
    logic [3:0]  rob_qry2_id;
    logic        rob_qry1_fi;
    logic        rob_qry2_fi;
    logic [31:0] rob_qry1_value;
    logic [31:0] rob_qry2_value;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_id;
    logic [31:0] cdb_value;
    logic        rob_clear;
    logic [31:0] rob_clear_pc;
    logic        rf_commit_en;
    logic [4:0]  rf_commit_reg;
    logic [31:0] rf_commit_value;
    logic [3:0]  rf_commit_rob_id;
    logic        lsb_commit_en;
    logic [3:0]  lsb_commit_rob_id;
    logic [31:0] perf_commit_cnt;
    logic [31:0] perf_mispredict_cnt;

    reorder_buffer #(.ROB_SIZE_BIT(4), .ROB_TYPE_BIT(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .rob_input(rob_input), .rob_fi(rob_fi), .rob_value(rob_value),
        .rob_addr(rob_addr), .rob_type(rob_type), .rob_reg_id(rob_reg_id),
        .rob_full(rob_full), .rob_vacant_id(rob_vacant_id),
        .rob_qry1_id(rob_qry1_id), .rob_qry2_id(rob_qry2_id),
        .rob_qry1_fi(rob_qry1_fi), .rob_qry2_fi(rob_qry2_fi),
        .rob_qry1_value(rob_qry1_value), .rob_qry2_value(rob_qry2_value),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
        .rob_clear(rob_clear), .rob_clear_pc(rob_clear_pc),
        .rf_commit_en(rf_commit_en), .rf_commit_reg(rf_commit_reg),
        .rf_commit_value(rf_commit_value), .rf_commit_rob_id(rf_commit_rob_id),
        .lsb_commit_en(lsb_commit_en), .lsb_commit_rob_id(lsb_commit_rob_id),
        .perf_commit_cnt(perf_commit_cnt), .perf_mispredict_cnt(perf_mispredict_cnt)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rdy_in = 1'b1; rob_input = 1'b0; rob_fi = 1'b0; rob_value = '0; rob_addr = '0;
        rob_type = ROB_REG; rob_reg_id = '0; cdb_valid = 1'b0; cdb_rob_id = '0;
        cdb_value = '0; rob_qry1_id = '0; rob_qry2_id = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rob_full"}, 32'(rob_full), 32'd0);
        check({tag, " vacant_id"}, 32'(rob_vacant_id), 32'd0);
        check({tag, " rob_clear"}, 32'(rob_clear), 32'd0);
        check({tag, " clear_pc"}, rob_clear_pc, 32'd0);
        check({tag, " rf_en"}, 32'(rf_commit_en), 32'd0);
        check({tag, " lsb_en"}, 32'(lsb_commit_en), 32'd0);
        check({tag, " perf_commit"}, perf_commit_cnt, 32'd0);
        check({tag, " perf_mispredict"}, perf_mispredict_cnt, 32'd0);
    endtask

    task automatic issue(input logic [1:0] t, input logic fi, input logic [31:0] v,
                         input logic [4:0] rd, input logic [31:0] a);
        rob_input = 1'b1; rob_type = t; rob_fi = fi; rob_value = v;
        rob_reg_id = rd; rob_addr = a;
        tick();
        rob_input = 1'b0;
    endtask

    // Query vector table
    typedef struct {
        logic [3:0]  q1;
        logic [3:0]  q2;
        logic        cv;
        logic [3:0]  cid;
        logic [31:0] cval;
        logic        f1;
        logic [31:0] v1;
        logic        f2;
        logic [31:0] v2;
    } qvec_t;
    qvec_t qtab[7];

    // Reference model: queue of live entries, oldest first
    typedef struct {
        int          id;
        logic        rdy;
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [31:0] addr;
    } ent_t;
    ent_t q[$];
    int   m_tail;
    logic m_clear;
    int   m_commits;
    int   m_flushes;

    function automatic void mquery(input logic [3:0] qid, output logic f, output logic [31:0] v);
        f = 1'b0;
        v = '0;
        foreach (q[i]) begin
            if (q[i].id == int'(qid) && q[i].rdy) begin
                f = 1'b1;
                v = q[i].val;
            end
        end
        if (cdb_valid && cdb_rob_id == qid) begin
            f = 1'b1;
            v = cdb_value;
        end
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    ent_t        h;
    ent_t        e;
    logic        did_commit;
    logic        flush;
    logic        e_rf;
    logic [4:0]  e_rd;
    logic [31:0] e_val;
    logic [3:0]  e_id;
    logic        e_lsb;
    logic [3:0]  e_lid;
    logic [31:0] e_pc;
    logic        ef;
    logic [31:0] ev;
    int          wrap_ids[4];

    initial begin
        idle();
        rst_in = 1'b1;

        // Reset values
        do_reset();
        check_reset_outputs("reset");

        // LUI-like entry complete at issue commits the next cycle
        issue(ROB_REG, 1'b1, 32'h1234_5000, 5'd5, 32'd0);
        check("lui issue rf_en", 32'(rf_commit_en), 32'd0);
        check("lui vacant", 32'(rob_vacant_id), 32'd1);
        tick();
        check("lui rf_en", 32'(rf_commit_en), 32'd1);
        check("lui rf_reg", 32'(rf_commit_reg), 32'd5);
        check("lui rf_value", rf_commit_value, 32'h1234_5000);
        check("lui rf_id", 32'(rf_commit_rob_id), 32'd0);
        tick();
        check("lui pulse drop", 32'(rf_commit_en), 32'd0);

        // ADD completed by CDB with same-cycle query bypass
        do_reset();
        issue(ROB_REG, 1'b0, 32'd0, 5'd3, 32'd0);
        rob_qry1_id = 4'd0;
        #1;
        check("add qry1_fi pending", 32'(rob_qry1_fi), 32'd0);
        cdb_valid = 1'b1; cdb_rob_id = 4'd0; cdb_value = 32'd7;
        #1;
        check("add qry1_fi bypass", 32'(rob_qry1_fi), 32'd1);
        check("add qry1_value bypass", rob_qry1_value, 32'd7);
        tick();
        cdb_valid = 1'b0;
        check("add no commit on wb edge", 32'(rf_commit_en), 32'd0);
        tick();
        check("add rf_en", 32'(rf_commit_en), 32'd1);
        check("add rf_value", rf_commit_value, 32'd7);
        check("add rf_reg", 32'(rf_commit_reg), 32'd3);

        // Query table with rdy_in low so nothing moves
        do_reset();
        issue(ROB_REG,  1'b0, 32'd0,     5'd1, 32'd0);
        issue(ROB_REGI, 1'b1, 32'h11,    5'd2, 32'd0);
        issue(ROB_REG,  1'b0, 32'd0,     5'd3, 32'd0);
        issue(ROB_ST,   1'b0, 32'd0,     5'd0, 32'd0);
        rdy_in = 1'b0;
        qtab[0] = '{4'd1, 4'd0, 1'b0, 4'd0, 32'd0,      1'b1, 32'h11,  1'b0, 32'd0};
        qtab[1] = '{4'd0, 4'd2, 1'b1, 4'd0, 32'h55,     1'b1, 32'h55,  1'b0, 32'd0};
        qtab[2] = '{4'd2, 4'd3, 1'b1, 4'd3, 32'hABC,    1'b0, 32'd0,   1'b1, 32'hABC};
        qtab[3] = '{4'd5, 4'd1, 1'b0, 4'd0, 32'd0,      1'b0, 32'd0,   1'b1, 32'h11};
        qtab[4] = '{4'd5, 4'd9, 1'b1, 4'd5, 32'd9,      1'b1, 32'd9,   1'b0, 32'd0};
        qtab[5] = '{4'd1, 4'd1, 1'b1, 4'd1, 32'h77,     1'b1, 32'h77,  1'b1, 32'h77};
        qtab[6] = '{4'd3, 4'd4, 1'b0, 4'd0, 32'd0,      1'b0, 32'd0,   1'b0, 32'd0};
        for (int i = 0; i < 7; i++) begin
            rob_qry1_id = qtab[i].q1; rob_qry2_id = qtab[i].q2;
            cdb_valid = qtab[i].cv; cdb_rob_id = qtab[i].cid; cdb_value = qtab[i].cval;
            #1;
            check($sformatf("qtab[%0d] fi1", i), 32'(rob_qry1_fi), 32'(qtab[i].f1));
            check($sformatf("qtab[%0d] fi2", i), 32'(rob_qry2_fi), 32'(qtab[i].f2));
            if (qtab[i].f1) check($sformatf("qtab[%0d] v1", i), rob_qry1_value, qtab[i].v1);
            if (qtab[i].f2) check($sformatf("qtab[%0d] v2", i), rob_qry2_value, qtab[i].v2);
        end
        cdb_valid = 1'b1; cdb_rob_id = 4'd0; cdb_value = 32'h99;
        tick();
        tick();
        cdb_valid = 1'b0;
        rdy_in = 1'b1;
        tick();
        check("paused cdb ignored rf_en", 32'(rf_commit_en), 32'd0);
        check("paused vacant held", 32'(rob_vacant_id), 32'd4);
        cdb_valid = 1'b1; cdb_rob_id = 4'd0; cdb_value = 32'h99;
        tick();
        cdb_valid = 1'b0;
        tick();
        check("resume commit id0 value", rf_commit_value, 32'h99);
        check("resume commit id0 reg", 32'(rf_commit_reg), 32'd1);
        tick();
        check("resume commit id1 value", rf_commit_value, 32'h11);
        check("resume commit id1 id", 32'(rf_commit_rob_id), 32'd1);

        // Fill to full, then free one slot
        do_reset();
        for (int i = 0; i < 15; i++) begin
            issue(ROB_REG, 1'b0, 32'd0, 5'(i + 1), 32'd0);
            if (i == 13) check("full at count 14", 32'(rob_full), 32'd0);
        end
        check("full at count 15", 32'(rob_full), 32'd1);
        check("full vacant", 32'(rob_vacant_id), 32'd15);
        cdb_valid = 1'b1; cdb_rob_id = 4'd0; cdb_value = 32'h42;
        tick();
        cdb_valid = 1'b0;
        check("full still after wb", 32'(rob_full), 32'd1);
        tick();
        check("full commit rf_en", 32'(rf_commit_en), 32'd1);
        check("full commit id", 32'(rf_commit_rob_id), 32'd0);
        check("full dropped", 32'(rob_full), 32'd0);
        check("full vacant after commit", 32'(rob_vacant_id), 32'd15);

        // Branch mispredict flush, issue during the flush cycle is ignored
        do_reset();
        issue(ROB_BR, 1'b0, 32'd0, 5'd1, 32'h104);
        issue(ROB_REG, 1'b0, 32'd0, 5'd4, 32'd0);
        cdb_valid = 1'b1; cdb_rob_id = 4'd0; cdb_value = 32'd0;
        tick();
        cdb_valid = 1'b0;
        tick();
        check("br rob_clear", 32'(rob_clear), 32'd1);
        check("br clear_pc", rob_clear_pc, 32'h104);
        check("br vacant", 32'(rob_vacant_id), 32'd0);
        check("br full", 32'(rob_full), 32'd0);
        rob_input = 1'b1; rob_fi = 1'b1; rob_type = ROB_REG; rob_reg_id = 5'd7; rob_value = 32'h777;
        cdb_valid = 1'b1; cdb_rob_id = 4'd1; cdb_value = 32'd5;
        tick();
        idle();
        check("br clear one cycle", 32'(rob_clear), 32'd0);
        check("br issue ignored vacant", 32'(rob_vacant_id), 32'd0);
        tick();
        check("br nothing commits", 32'(rf_commit_en), 32'd0);

        // Tail wrap: commits 14, 15, 0, 1 in order
        do_reset();
        wrap_ids = '{14, 15, 0, 1};
        rob_input = 1'b1; rob_fi = 1'b1; rob_type = ROB_REG; rob_reg_id = 5'd1;
        for (int i = 0; i < 14; i++) begin
            rob_value = 32'(i);
            tick();
        end
        rob_reg_id = 5'd9;
        for (int k = 0; k < 4; k++) begin
            rob_value = 32'h100 + 32'(k);
            tick();
            if (k >= 1) begin
                check($sformatf("wrap commit %0d id", k - 1), 32'(rf_commit_rob_id), 32'(wrap_ids[k - 1]));
                check($sformatf("wrap commit %0d value", k - 1), rf_commit_value, 32'h100 + 32'(k - 1));
            end
        end
        check("wrap vacant", 32'(rob_vacant_id), 32'd2);
        rob_input = 1'b0;
        tick();
        check("wrap commit 3 id", 32'(rf_commit_rob_id), 32'(wrap_ids[3]));
        check("wrap commit 3 value", rf_commit_value, 32'h103);

        // Reset mid-stream with busy entries
        do_reset();
        for (int i = 0; i < 3; i++) issue(ROB_REG, 1'b1, 32'(i), 5'd2, 32'd0);
        for (int i = 0; i < 5; i++) issue(ROB_REG, 1'b0, 32'd0, 5'd3, 32'd0);
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
        check_reset_outputs("midreset");
        cdb_valid = 1'b1; cdb_rob_id = 4'd4; cdb_value = 32'd1;
        tick();
        cdb_valid = 1'b0;
        tick();
        check("midreset stale cdb no commit", 32'(rf_commit_en), 32'd0);

        // Randomized run against the queue model
        do_reset();
        q.delete();
        m_tail = 0; m_clear = 1'b0; m_commits = 0; m_flushes = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rob_input  = (q.size() < 15) && ($urandom_range(0, 99) < 60);
            rob_fi     = ($urandom_range(0, 2) == 0);
            rob_type   = 2'($urandom_range(0, 3));
            rob_reg_id = 5'($urandom_range(0, 31));
            rob_value  = $urandom();
            rob_addr   = $urandom();
            cdb_valid  = ($urandom_range(0, 1) == 1);
            if (q.size() > 0 && $urandom_range(0, 9) < 8)
                cdb_rob_id = 4'(q[$urandom_range(0, q.size() - 1)].id);
            else
                cdb_rob_id = 4'($urandom_range(0, 15));
            cdb_value = $urandom();
            if (q.size() > 0 && $urandom_range(0, 1) == 1)
                rob_qry1_id = 4'(q[$urandom_range(0, q.size() - 1)].id);
            else
                rob_qry1_id = 4'($urandom_range(0, 15));
            rob_qry2_id = 4'($urandom_range(0, 15));
            #1;
            mquery(rob_qry1_id, ef, ev);
            check("rand qry1_fi", 32'(rob_qry1_fi), 32'(ef));
            if (ef) check("rand qry1_value", rob_qry1_value, ev);
            mquery(rob_qry2_id, ef, ev);
            check("rand qry2_fi", 32'(rob_qry2_fi), 32'(ef));
            if (ef) check("rand qry2_value", rob_qry2_value, ev);

            e_rf = 1'b0; e_lsb = 1'b0; flush = 1'b0; did_commit = 1'b0;
            e_rd = '0; e_val = '0; e_id = '0; e_lid = '0; e_pc = '0;
            if (q.size() > 0 && q[0].rdy) begin
                h = q.pop_front();
                did_commit = 1'b1;
                m_commits++;
                if (h.typ == ROB_REG || h.typ == ROB_REGI) begin
                    e_rf = (h.rd != 5'd0); e_rd = h.rd; e_val = h.val; e_id = 4'(h.id);
                end
                if (h.typ == ROB_ST) begin
                    e_lsb = 1'b1; e_lid = 4'(h.id);
                end
                if (h.typ == ROB_BR && h.rd[0] != h.val[0]) flush = 1'b1;
            end
            if (flush) begin
                q.delete();
                m_tail = 0;
                e_pc = h.addr;
                m_flushes++;
            end else if (!m_clear) begin
                if (cdb_valid) begin
                    foreach (q[i]) begin
                        if (q[i].id == int'(cdb_rob_id)) begin
                            q[i].rdy = 1'b1;
                            q[i].val = cdb_value;
                        end
                    end
                end
                if (rob_input) begin
                    e.id = m_tail; e.rdy = rob_fi; e.typ = rob_type; e.rd = rob_reg_id;
                    e.val = rob_value; e.addr = rob_addr;
                    q.push_back(e);
                    m_tail = (m_tail + 1) % 16;
                end
            end
            m_clear = flush;

            tick();
            check("rand rf_en", 32'(rf_commit_en), 32'(e_rf));
            if (e_rf) begin
                check("rand rf_reg", 32'(rf_commit_reg), 32'(e_rd));
                check("rand rf_value", rf_commit_value, e_val);
                check("rand rf_id", 32'(rf_commit_rob_id), 32'(e_id));
            end
            check("rand lsb_en", 32'(lsb_commit_en), 32'(e_lsb));
            if (e_lsb) check("rand lsb_id", 32'(lsb_commit_rob_id), 32'(e_lid));
            check("rand rob_clear", 32'(rob_clear), 32'(flush));
            if (flush) check("rand clear_pc", rob_clear_pc, e_pc);
            check("rand rob_full", 32'(rob_full), 32'(q.size() >= 15));
            check("rand vacant", 32'(rob_vacant_id), 32'(m_tail));
`ifdef ROB_PERF_CNT_EN
            check("rand perf_commit", perf_commit_cnt, 32'(m_commits));
            check("rand perf_mispredict", perf_mispredict_cnt, 32'(m_flushes));
`else
            check("rand perf_commit", perf_commit_cnt, 32'd0);
            check("rand perf_mispredict", perf_mispredict_cnt, 32'd0);
`endif
        end
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
